// File: rtl/imm_instr_encoder_if.sv
// rtl/imm_instr_encoder_if.sv - request/response bus of the immediate instruction encoder
interface imm_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              InValid;
  logic              InReady;
  logic [6:0]        InOpcode;
  logic [4:0]        InRd;
  logic [4:0]        InRs1;
  logic [4:0]        InRs2;
  logic [2:0]        InFunct3;
  logic [63:0]       InImm;
  logic              OutValid;
  logic              OutReady;
  logic [31:0]       OutInstr;
  logic [ADDR_W-1:0] OutAddr;

  modport master (
    output InValid, InOpcode, InRd, InRs1, InRs2, InFunct3, InImm, OutReady,
    input  InReady, OutValid, OutInstr, OutAddr
  );

  modport slave (
    input  InValid, InOpcode, InRd, InRs1, InRs2, InFunct3, InImm, OutReady,
    output InReady, OutValid, OutInstr, OutAddr
  );
endinterface

// File: rtl/imm_instr_encoder.sv
// rtl/imm_instr_encoder.sv - packs I/S/B fields into RV64 words with sequential addresses (optional IMM_ENC_ROUNDTRIP_EN checker)
module imm_instr_encoder #(
  parameter int ADDR_W      = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  imm_instr_encoder_if.slave  bus,
  input  logic                Clear,
  output logic                ErrFlag,
  output logic [7:0]          ErrCount,
  output logic                Halted,
  output logic                CheckErr
);
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              err_flag_q, err_flag_d;
  logic [7:0]        err_count_q, err_count_d;

  logic        is_i, is_s, is_b;
  logic        fits12, fits13, legal;
  logic [31:0] enc_word;
  logic        in_ready, accept, take_good, take_bad, word_done;

  // Format decode, immediate range check and field packing
  always_comb begin
    is_i     = (bus.InOpcode == OP_IMM) || (bus.InOpcode == OP_LOAD);
    is_s     = (bus.InOpcode == OP_STORE);
    is_b     = (bus.InOpcode == OP_BRANCH);
    fits12   = (&bus.InImm[63:11]) || !(|bus.InImm[63:11]);
    fits13   = (&bus.InImm[63:12]) || !(|bus.InImm[63:12]);
    legal    = ((is_i || is_s) && fits12) || (is_b && fits13 && !bus.InImm[0]);
    enc_word = '0;
    if (is_i) begin
      enc_word = {bus.InImm[11:0], bus.InRs1, bus.InFunct3, bus.InRd, bus.InOpcode};
    end else if (is_s) begin
      enc_word = {bus.InImm[11:5], bus.InRs2, bus.InRs1, bus.InFunct3,
                  bus.InImm[4:0], bus.InOpcode};
    end else if (is_b) begin
      enc_word = {bus.InImm[12], bus.InImm[10:5], bus.InRs2, bus.InRs1, bus.InFunct3,
                  bus.InImm[4:1], bus.InImm[11], bus.InOpcode};
    end
  end

  // Single output register: a new request fits only when the slot is empty or draining
  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.OutReady);
  assign accept    = bus.InValid && in_ready;
  assign take_good = accept && legal;
  assign take_bad  = accept && !legal;
  assign word_done = out_valid_q && bus.OutReady;

  // Run/halt control: a rejected request halts only when configured to
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (take_bad && HALT_ON_ERR) state_d = ST_HALT;
      ST_HALT: if (Clear) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Output word, address counter and error bookkeeping; Clear applies before a same-cycle error
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (word_done) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + ADDR_W'(1);
    end
    if (take_good) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_word;
    end
    if (Clear) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
    if (take_bad) begin
      err_flag_d = 1'b1;
      if (err_count_d != 8'hFF) err_count_d = err_count_d + 8'd1;
    end
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid_q;
  assign bus.OutInstr = out_instr_q;
  assign bus.OutAddr  = out_addr_q;
  assign ErrFlag      = err_flag_q;
  assign ErrCount     = err_count_q;
  assign Halted       = (state_q == ST_HALT);

`ifdef IMM_ENC_ROUNDTRIP_EN
  logic [63:0] dec_imm;
  logic        check_err_q, check_err_d;

  // Re-extract the immediate from the packed word as the immediate generator would
  always_comb begin
    dec_imm = '0;
    if (is_i) begin
      dec_imm = {{52{enc_word[31]}}, enc_word[31:20]};
    end else if (is_s) begin
      dec_imm = {{52{enc_word[31]}}, enc_word[31:25], enc_word[11:7]};
    end else if (is_b) begin
      dec_imm = {{51{enc_word[31]}}, enc_word[31], enc_word[7], enc_word[30:25],
                 enc_word[11:8], 1'b0};
    end
  end

  // Sticky mismatch flag, set alongside the word being loaded into the output register
  always_comb begin
    check_err_d = Clear ? 1'b0 : check_err_q;
    if (take_good && (dec_imm != bus.InImm)) check_err_d = 1'b1;
  end

  // Mismatch flag register
  always_ff @(posedge clk) begin
    if (!rst_n) check_err_q <= 1'b0;
    else        check_err_q <= check_err_d;
  end

  assign CheckErr = check_err_q;
`else
  assign CheckErr = 1'b0;
`endif
endmodule
